// File: rtl/mul_final_adder.sv
// mul_final_adder: bit-serial carry-propagate stage for the carry-save multiplier.
// Adds the last-row sum/carry vectors one bit per cycle with a single full adder
// and presents {high, low} together with a one-cycle done pulse.
module mul_final_adder #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     ps,
    input  logic [W-1:0]     pc,
    input  logic [W-1:0]     low,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product,
    output logic             cout
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAdd  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           c_q, c_d;
    logic [W-1:0]   ps_q, ps_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   low_q, low_d;
    logic [W-1:0]   hs_q, hs_d;
    logic [2*W-1:0] product_q, product_d;
    logic           cout_q, cout_d;

    logic           bit_a, bit_b, bit_s, bit_c;
    logic [W-1:0]   hs_shift;

    // Full-adder cell, next-state and sequencing for the serial addition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        ps_d      = ps_q;
        pc_d      = pc_q;
        low_d     = low_q;
        hs_d      = hs_q;
        product_d = product_q;
        cout_d    = cout_q;

        bit_a    = ps_q[cnt_q];
        bit_b    = pc_q[cnt_q];
        bit_s    = bit_a ^ bit_b ^ c_q;
        bit_c    = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
        // New sum bit enters at the MSB so bit j lands at hs[j] after W shifts
        hs_shift = {bit_s, hs_q[W-1:1]};

        case (state_q)
            StIdle: begin
                if (start) begin
                    ps_d    = ps;
                    pc_d    = pc;
                    low_d   = low;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                c_d   = bit_c;
                hs_d  = hs_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    product_d = {hs_shift, low_q};
                    cout_d    = bit_c;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; synchronous reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            ps_q      <= '0;
            pc_q      <= '0;
            low_q     <= '0;
            hs_q      <= '0;
            product_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            c_q       <= c_d;
            ps_q      <= ps_d;
            pc_q      <= pc_d;
            low_q     <= low_d;
            hs_q      <= hs_d;
            product_q <= product_d;
            cout_q    <= cout_d;
        end
    end

    assign busy    = (state_q == StAdd);
    assign done    = (state_q == StDone);
    assign product = product_q;
    assign cout    = cout_q;

endmodule

// File: doc/mul_final_adder.md
# mul_final_adder

Bit-serial carry-propagate stage placed directly downstream of the carry-save multiplier array. It accepts the redundant sum/carry vectors from the array's last row together with the already-resolved low product bits. It resolves the upper half over W cycles, one bit per cycle, and presents the full 2W-bit product with a one-cycle completion pulse. The area cost is one full-adder cell plus a counter, in place of a W-bit ripple adder.

## Interface
Parameters:
- W, 8: width of each operand, and of the sum/carry vectors from the last array row (W ≥ 2).

Ports (clock and reset: one clock, synchronous active-high reset):
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- ps  in  W  partial-sum vector from the last array row (po outputs).
- pc  in  W  carry vector from the last array row (co outputs), aligned to the same weights as ps.
- low  in  W  low product bits P[W-1:0], already resolved by the array.
- busy  out  1  high while bits are being resolved (state ADD).
- done  out  1  one-cycle pulse; product is valid from this cycle.
- product  out  2W  result register: {high, low}.
- cout  out  1  carry out of the high-half addition; must be 0 for a correct unsigned W×W result.

## Operation
- States: IDLE, ADD, DONE.
- IDLE with start=1:
  - Latch ps, pc, low into internal registers.
  - Clear the carry flip-flop c and bit counter cnt (width ⌈log2 W⌉).
  - Go to ADD.
- IDLE with start=0: stay in IDLE.
- ADD, each cycle (i = cnt):
  - s = ps[i]^pc[i]^c; c ← maj(ps[i], pc[i], c).
  - s is right-shifted into the MSB of an internal W-bit shift register hs. After W shifts, hs[j] = bit j of the sum.
  - cnt increments.
  - When cnt = W-1 (last bit):
    - product ← {hs_final, low_latched}, where hs_final includes this cycle's s.
    - cout ← final carry.
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- start during ADD or DONE is ignored; it is not queued.
- Inputs ps/pc/low are don't-care except in the cycle start is sampled.
- Arithmetic: high = (ps + pc) mod 2^W, unsigned. cout = bit W of ps + pc.
- product and cout change only at the completion edge and hold their value until the next completion.
- Reset (any state, including mid-ADD):
  - state=IDLE, busy=0, done=0, product=0, cout=0, cnt=0, c=0.
  - Any in-flight operation is discarded and no done is issued.

## Timing
- E0: the edge at which start is sampled in IDLE.
- busy is high for exactly W cycles: after E0 through E(W). Bit i is resolved at edge E(i+1).
- done is high in the single cycle after E(W), coincident with busy=0.
- Latency from start sampled to done asserted: W cycles. Initiation interval: W+2 cycles.
  - The earliest next start is sampled at E(W+2), the first IDLE edge after DONE.
- No combinational path from inputs to outputs; all outputs are registers or state decodes.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then start=0 for 20 cycles → busy=0, done=0, product=0, cout=0 throughout.
- Basic (W=8): ps=0x0F, pc=0x01, low=0xA5, start for 1 cycle → busy high 8 cycles; done pulse 8 cycles after start; product=0x10A5, cout=0.
- Carry chain/overflow: ps=0xFF, pc=0xFF, low=0x00 → product=0xFE00, cout=1. Then ps=0x80, pc=0x80, low=0x01 → product=0x0001, cout=1.
- Start while busy: start held high continuously from E0 with ps=0x03, pc=0x04, low=0x10 →
  - First done after 8 cycles: product=0x0710.
  - Next operation begins at E10; a second done occurs 8 cycles later, i.e. 10 cycles after the first done.
  - Exactly one done per accepted start; no done is issued for the ignored starts.
- Reset mid-operation: start with ps=0xAA, pc=0x55, then rst=1 at E4 → IDLE, busy=0, product=0, no done pulse. A following start with ps=0x01, pc=0x01, low=0x00 yields product=0x0200, cout=0.
- End-to-end: drive from the array for random 8-bit x, y over 1000 operations → product equals x*y and cout=0 every time.
